multicycle_ctrl: RTL

- Multi-cycle main control unit for the MIPS datapath.
- Replaces the single-cycle opcode decoder with a state machine that sequences fetch, decode, execute, memory and write-back over several cycles.
- Adds lw, sw and j, gives slti its own ALU op code, waits on a memory ready handshake, and traps on illegal opcodes.
- Sits between the instruction register's opcode field and every datapath mux and enable.

---
 rtl/mc_pkg.sv | 84 ++++++++
 rtl/mc_ctrl_rom.sv | 85 ++++++++
 rtl/multicycle_ctrl.sv | 81 ++++++++
 3 files changed

// File: rtl/mc_pkg.sv
// Shared constants and types for the multi-cycle MIPS main control unit.
package mc_pkg;

  localparam int MC_OP_W       = 6;
  localparam int MC_ALU_OP_W   = 3;
  localparam int MC_PC_SRC_W   = 2;

  // Opcode field values (IR[31:26])
  localparam logic [MC_OP_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [MC_OP_W-1:0] OP_J     = 6'b000010;
  localparam logic [MC_OP_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [MC_OP_W-1:0] OP_ADDI  = 6'b001000;
  localparam logic [MC_OP_W-1:0] OP_SLTI  = 6'b001010;
  localparam logic [MC_OP_W-1:0] OP_LW    = 6'b100011;
  localparam logic [MC_OP_W-1:0] OP_SW    = 6'b101011;

  // ALU op codes sent to ALU_Ctrl
  localparam logic [MC_ALU_OP_W-1:0] ALU_ADD   = 3'b000;
  localparam logic [MC_ALU_OP_W-1:0] ALU_SUB   = 3'b001;
  localparam logic [MC_ALU_OP_W-1:0] ALU_FUNCT = 3'b010;
  localparam logic [MC_ALU_OP_W-1:0] ALU_ADDI  = 3'b011;
  localparam logic [MC_ALU_OP_W-1:0] ALU_SLTI  = 3'b100;

  // ALU operand and PC source selects
  localparam logic       SRCA_PC      = 1'b0;
  localparam logic       SRCA_RS      = 1'b1;
  localparam logic [1:0] SRCB_RT      = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;
  localparam logic [MC_PC_SRC_W-1:0] PCSRC_ALU    = 2'b00;
  localparam logic [MC_PC_SRC_W-1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [MC_PC_SRC_W-1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    ST_FETCH    = 4'd0,
    ST_DECODE   = 4'd1,
    ST_MEM_ADDR = 4'd2,
    ST_MEM_RD   = 4'd3,
    ST_MEM_WB   = 4'd4,
    ST_MEM_WR   = 4'd5,
    ST_EXEC_R   = 4'd6,
    ST_R_WB     = 4'd7,
    ST_EXEC_I   = 4'd8,
    ST_I_WB     = 4'd9,
    ST_BRANCH   = 4'd10,
    ST_JUMP     = 4'd11,
    ST_TRAP     = 4'd12
  } state_e;

  // Full control word produced by the state decode
  typedef struct packed {
    logic                   mem_req;
    logic                   mem_read;
    logic                   mem_write;
    logic                   i_or_d;
    logic                   ir_write;
    logic                   pc_write;
    logic                   pc_write_cond;
    logic [MC_PC_SRC_W-1:0] pc_src;
    logic                   alu_src_a;
    logic [1:0]             alu_src_b;
    logic [MC_ALU_OP_W-1:0] alu_op;
    logic                   reg_dst;
    logic                   mem_to_reg;
    logic                   reg_write;
    logic                   illegal;
  } ctrl_t;

  // Dispatch target out of DECODE for a given opcode
  function automatic state_e decode_next(input logic [MC_OP_W-1:0] op);
    state_e nxt;
    case (op)
      OP_RTYPE:       nxt = ST_EXEC_R;
      OP_LW, OP_SW:   nxt = ST_MEM_ADDR;
      OP_ADDI, OP_SLTI: nxt = ST_EXEC_I;
      OP_BEQ:         nxt = ST_BRANCH;
      OP_J:           nxt = ST_JUMP;
      default:        nxt = ST_TRAP;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/mc_ctrl_rom.sv
// Combinational map from FSM state (and opcode, for EXEC_I) to control word.
module mc_ctrl_rom
  import mc_pkg::*;
(
  input  logic [3:0]         state_i,
  input  logic [MC_OP_W-1:0] op_i,
  output ctrl_t              ctrl_o
);

  // Moore decode; unused encodings fall through to an all-zero word
  always_comb begin
    ctrl_o = '0;
    case (state_i)
      ST_FETCH: begin
        ctrl_o.mem_req   = 1'b1;
        ctrl_o.mem_read  = 1'b1;
        ctrl_o.i_or_d    = 1'b0;
        ctrl_o.ir_write  = 1'b1;  // qualified by mem_ready in the top
        ctrl_o.pc_write  = 1'b1;  // qualified by mem_ready in the top
        ctrl_o.alu_src_a = SRCA_PC;
        ctrl_o.alu_src_b = SRCB_FOUR;
        ctrl_o.alu_op    = ALU_ADD;
        ctrl_o.pc_src    = PCSRC_ALU;
      end
      ST_DECODE: begin
        ctrl_o.alu_src_a = SRCA_PC;
        ctrl_o.alu_src_b = SRCB_IMM_SH2;
        ctrl_o.alu_op    = ALU_ADD;
      end
      ST_MEM_ADDR: begin
        ctrl_o.alu_src_a = SRCA_RS;
        ctrl_o.alu_src_b = SRCB_IMM;
        ctrl_o.alu_op    = ALU_ADD;
      end
      ST_MEM_RD: begin
        ctrl_o.mem_req  = 1'b1;
        ctrl_o.mem_read = 1'b1;
        ctrl_o.i_or_d   = 1'b1;
      end
      ST_MEM_WB: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.mem_to_reg = 1'b1;
        ctrl_o.reg_dst    = 1'b0;
      end
      ST_MEM_WR: begin
        ctrl_o.mem_req   = 1'b1;
        ctrl_o.mem_write = 1'b1;
        ctrl_o.i_or_d    = 1'b1;
      end
      ST_EXEC_R: begin
        ctrl_o.alu_src_a = SRCA_RS;
        ctrl_o.alu_src_b = SRCB_RT;
        ctrl_o.alu_op    = ALU_FUNCT;
      end
      ST_R_WB: begin
        ctrl_o.reg_write = 1'b1;
        ctrl_o.reg_dst   = 1'b1;
      end
      ST_EXEC_I: begin
        ctrl_o.alu_src_a = SRCA_RS;
        ctrl_o.alu_src_b = SRCB_IMM;
        ctrl_o.alu_op    = (op_i == OP_SLTI) ? ALU_SLTI : ALU_ADDI;
      end
      ST_I_WB: begin
        ctrl_o.reg_write = 1'b1;
      end
      ST_BRANCH: begin
        ctrl_o.alu_src_a     = SRCA_RS;
        ctrl_o.alu_src_b     = SRCB_RT;
        ctrl_o.alu_op        = ALU_SUB;
        ctrl_o.pc_write_cond = 1'b1;
        ctrl_o.pc_src        = PCSRC_ALUOUT;
      end
      ST_JUMP: begin
        ctrl_o.pc_write = 1'b1;
        ctrl_o.pc_src   = PCSRC_JUMP;
      end
      ST_TRAP: begin
        ctrl_o.illegal = 1'b1;
      end
      default: ctrl_o = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS main control: state register, sequencing and handshake gating.
module multicycle_ctrl
  import mc_pkg::*;
#(
  parameter int OP_W     = 6,
  parameter int ALU_OP_W = 3,
  parameter int PC_SRC_W = 2
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [OP_W-1:0]     instr_op_i,
  input  logic                mem_ready_i,
  output logic                mem_req_o,
  output logic                mem_read_o,
  output logic                mem_write_o,
  output logic                i_or_d_o,
  output logic                ir_write_o,
  output logic                pc_write_o,
  output logic                pc_write_cond_o,
  output logic [PC_SRC_W-1:0] pc_src_o,
  output logic                alu_src_a_o,
  output logic [1:0]          alu_src_b_o,
  output logic [ALU_OP_W-1:0] alu_op_o,
  output logic                reg_dst_o,
  output logic                mem_to_reg_o,
  output logic                reg_write_o,
  output logic                illegal_o,
  output logic [3:0]          state_o
);

  state_e state_q;
  ctrl_t  ctrl;
  logic   in_fetch;

  // State register and next-state sequencing; reset wins in every state
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_FETCH;
    end else begin
      case (state_q)
        ST_FETCH:    if (mem_ready_i) state_q <= ST_DECODE;
        ST_DECODE:   state_q <= decode_next(instr_op_i);
        ST_MEM_ADDR: state_q <= (instr_op_i == OP_SW) ? ST_MEM_WR : ST_MEM_RD;
        ST_MEM_RD:   if (mem_ready_i) state_q <= ST_MEM_WB;
        ST_MEM_WR:   if (mem_ready_i) state_q <= ST_FETCH;
        ST_EXEC_R:   state_q <= ST_R_WB;
        ST_EXEC_I:   state_q <= ST_I_WB;
        ST_TRAP:     state_q <= ST_TRAP;
        default:     state_q <= ST_FETCH;  // WB/branch/jump and unused codes
      endcase
    end
  end

  mc_ctrl_rom u_rom (
    .state_i (state_q),
    .op_i    (instr_op_i),
    .ctrl_o  (ctrl)
  );

  assign in_fetch = (state_q == ST_FETCH);

  // Write strobes are suppressed while reset is held; IR/PC loads in FETCH
  // only fire on the cycle the instruction word actually arrives.
  assign mem_req_o       = ctrl.mem_req;
  assign mem_read_o      = ctrl.mem_read;
  assign mem_write_o     = ctrl.mem_write & ~rst_i;
  assign i_or_d_o        = ctrl.i_or_d;
  assign ir_write_o      = ctrl.ir_write & mem_ready_i & ~rst_i;
  assign pc_write_o      = ctrl.pc_write & (~in_fetch | mem_ready_i) & ~rst_i;
  assign pc_write_cond_o = ctrl.pc_write_cond & ~rst_i;
  assign pc_src_o        = ctrl.pc_src;
  assign alu_src_a_o     = ctrl.alu_src_a;
  assign alu_src_b_o     = ctrl.alu_src_b;
  assign alu_op_o        = ctrl.alu_op;
  assign reg_dst_o       = ctrl.reg_dst;
  assign mem_to_reg_o    = ctrl.mem_to_reg;
  assign reg_write_o     = ctrl.reg_write & ~rst_i;
  assign illegal_o       = ctrl.illegal;
  assign state_o         = state_q;

endmodule
